// File: rtl/ebus_diag_pkg.sv
// ebus_diag_pkg: shared types and constants for the EBUS diagnostic-function
// sequencer. Provides the sequencer state enum, the DS/data widths, a few
// named function codes and the read/load classifier.
package ebus_diag_pkg;

  localparam int DS_W   = 7;
  localparam int DATA_W = 36;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } diag_seq_state_t;

  // DS[0] is the leftmost (MSB) bit: 0xx codes load, 1xx codes read.
  localparam logic [0:DS_W-1] DS_LD_FUNC_076 = 7'o076;
  localparam logic [0:DS_W-1] DS_READ_10X    = 7'o100;

  function automatic logic ds_is_read(input logic [0:DS_W-1] ds);
    return ds[0];
  endfunction

endpackage

// File: rtl/ebus_diag_arb.sv
// ebus_diag_arb: fixed-priority two-way grant for the diag sequencer.
//   clk, reset        : clock, synchronous active-high reset
//   i_fe_req/i_uc_req : console / microcode request levels
//   i_grant_en        : sequencer is idle and may accept a grant this cycle
//   i_release         : sequencer is leaving DONE, drop the ownership record
//   o_grant           : a grant is taken at the end of this cycle
//   o_grant_fe        : that grant goes to the console
//   o_owner_fe        : registered record of a console grant (console_owner)
module ebus_diag_arb (
  input  logic clk,
  input  logic reset,
  input  logic i_fe_req,
  input  logic i_uc_req,
  input  logic i_grant_en,
  input  logic i_release,
  output logic o_grant,
  output logic o_grant_fe,
  output logic o_owner_fe
);

  logic r_owner_fe;

  // Console always wins a tie; microcode simply stays pending.
  assign o_grant    = i_grant_en & (i_fe_req | i_uc_req);
  assign o_grant_fe = i_grant_en & i_fe_req;
  assign o_owner_fe = r_owner_fe;

  always_ff @(posedge clk) begin
    if (reset)          r_owner_fe <= 1'b0;
    else if (o_grant)   r_owner_fe <= o_grant_fe;
    else if (i_release) r_owner_fe <= 1'b0;
  end

endmodule

// File: rtl/ebus_diag_seq.sv
// ebus_diag_seq: sequences one diagnostic function transfer at a time onto
// the EBUS diag lines (DS, diag strobe, data) for the console or microcode.
//   clk, reset                  : clock, synchronous active-high reset
//   fe_req/fe_ds/fe_wdata/fe_ack: console request, code, load data, done pulse
//   uc_req/uc_ds/uc_wdata/uc_ack: microcode request, code, load data, done pulse
//   rdata                       : last captured read data
//   ds_out/diag_strobe/data_oe/ebus_wdata/ebus_rdata : EBUS diag interface
//   console_owner, busy         : status
// All outputs are registered from the next-state decode, so each phase's
// values appear in the first cycle of that phase.
module ebus_diag_seq
  import ebus_diag_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fe_req,
  input  logic [0:DS_W-1]   fe_ds,
  input  logic [0:DATA_W-1] fe_wdata,
  output logic              fe_ack,
  input  logic              uc_req,
  input  logic [0:DS_W-1]   uc_ds,
  input  logic [0:DATA_W-1] uc_wdata,
  output logic              uc_ack,
  output logic [0:DATA_W-1] rdata,
  output logic [0:DS_W-1]   ds_out,
  output logic              diag_strobe,
  output logic              data_oe,
  output logic [0:DATA_W-1] ebus_wdata,
  input  logic [0:DATA_W-1] ebus_rdata,
  output logic              console_owner,
  output logic              busy
);

  localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  diag_seq_state_t   r_state, w_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_last;
  logic [0:DS_W-1]   r_ds, w_cur_ds;
  logic [0:DATA_W-1] r_wdata, w_cur_wdata;
  logic              r_rd, w_cur_rd;
  logic              w_grant, w_grant_fe, w_owner_fe, w_active;

  ebus_diag_arb u_arb (
    .clk        (clk),
    .reset      (reset),
    .i_fe_req   (fe_req),
    .i_uc_req   (uc_req),
    .i_grant_en (r_state == IDLE),
    .i_release  (r_state == DONE),
    .o_grant    (w_grant),
    .o_grant_fe (w_grant_fe),
    .o_owner_fe (w_owner_fe)
  );

  assign console_owner = w_owner_fe;
  assign w_last        = (r_cnt == '0);

  // On the grant edge the latches are still loading, so drive from the
  // winner's inputs directly; afterwards the latched copy is authoritative.
  assign w_cur_ds    = (r_state == IDLE) ? (w_grant_fe ? fe_ds : uc_ds) : r_ds;
  assign w_cur_wdata = (r_state == IDLE) ? (w_grant_fe ? fe_wdata : uc_wdata) : r_wdata;
  assign w_cur_rd    = (r_state == IDLE) ? ds_is_read(w_cur_ds) : r_rd;
  assign w_active    = (w_nxt == SETUP) || (w_nxt == STROBE) || (w_nxt == HOLD);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_nxt = SETUP;
      SETUP:   if (w_last)  w_nxt = STROBE;
      STROBE:  if (w_last)  w_nxt = HOLD;
      HOLD:    if (w_last)  w_nxt = DONE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ds        <= '0;
      r_wdata     <= '0;
      r_rd        <= 1'b0;
      ds_out      <= '0;
      diag_strobe <= 1'b0;
      data_oe     <= 1'b0;
      ebus_wdata  <= '0;
      rdata       <= '0;
      fe_ack      <= 1'b0;
      uc_ack      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state <= w_nxt;

      if (w_grant) begin
        r_ds    <= w_cur_ds;
        r_wdata <= w_cur_wdata;
        r_rd    <= w_cur_rd;
      end

      // One down-counter for every timed phase, reloaded on each entry.
      if (w_nxt != r_state) begin
        case (w_nxt)
          SETUP:   r_cnt <= CNT_W'(SETUP_CYC - 1);
          STROBE:  r_cnt <= CNT_W'(STROBE_CYC - 1);
          HOLD:    r_cnt <= CNT_W'(HOLD_CYC - 1);
          default: r_cnt <= '0;
        endcase
      end else if (!w_last) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      ds_out      <= w_active ? w_cur_ds : '0;
      data_oe     <= w_active && !w_cur_rd;
      ebus_wdata  <= (w_active && !w_cur_rd) ? w_cur_wdata : '0;
      diag_strobe <= (w_nxt == STROBE);
      busy        <= (w_nxt != IDLE);
      fe_ack      <= (w_nxt == DONE) &&  w_owner_fe;
      uc_ack      <= (w_nxt == DONE) && !w_owner_fe;

      if ((r_state == STROBE) && w_last && r_rd)
        rdata <= ebus_rdata;
    end
  end

endmodule

// File: tb/tb_ebus_diag_seq.sv
module tb_ebus_diag_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        fe_req, uc_req;
  logic [0:6]  fe_ds, uc_ds;
  logic [0:35] fe_wdata, uc_wdata, ebus_rdata;
  logic        fe_ack, uc_ack, diag_strobe, data_oe, console_owner, busy;
  logic [0:35] rdata, ebus_wdata;
  logic [0:6]  ds_out;

  // second instance with non-default timing
  logic        p_fe_req;
  logic [0:6]  p_fe_ds;
  logic [0:35] p_fe_wdata;
  logic        p_fe_ack, p_uc_ack, p_diag_strobe, p_data_oe, p_console_owner, p_busy;
  logic [0:35] p_rdata, p_ebus_wdata;
  logic [0:6]  p_ds_out;

  always #5 clk = ~clk;

  ebus_diag_seq dut (
    .clk(clk), .reset(reset),
    .fe_req(fe_req), .fe_ds(fe_ds), .fe_wdata(fe_wdata), .fe_ack(fe_ack),
    .uc_req(uc_req), .uc_ds(uc_ds), .uc_wdata(uc_wdata), .uc_ack(uc_ack),
    .rdata(rdata), .ds_out(ds_out), .diag_strobe(diag_strobe), .data_oe(data_oe),
    .ebus_wdata(ebus_wdata), .ebus_rdata(ebus_rdata),
    .console_owner(console_owner), .busy(busy)
  );

  ebus_diag_seq #(.SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(2)) dut_p (
    .clk(clk), .reset(reset),
    .fe_req(p_fe_req), .fe_ds(p_fe_ds), .fe_wdata(p_fe_wdata), .fe_ack(p_fe_ack),
    .uc_req(1'b0), .uc_ds(7'd0), .uc_wdata(36'd0), .uc_ack(p_uc_ack),
    .rdata(p_rdata), .ds_out(p_ds_out), .diag_strobe(p_diag_strobe), .data_oe(p_data_oe),
    .ebus_wdata(p_ebus_wdata), .ebus_rdata(36'o777000777000),
    .console_owner(p_console_owner), .busy(p_busy)
  );

  typedef struct {
    bit          fe;
    logic [0:6]  ds;
    logic [0:35] wd;
    logic [35:0] rv;
    logic [35:0] exp_rd;
  } xfer_t;

  xfer_t       sb[$];
  logic [35:0] mdl_rd;
  int          n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic request(input bit fe, input logic [0:6] ds, input logic [0:35] wd,
                         input logic [35:0] rv);
    xfer_t e;
    e.fe = fe; e.ds = ds; e.wd = wd; e.rv = rv;
    if (ds[0]) mdl_rd = rv;
    e.exp_rd = mdl_rd;
    sb.push_back(e);
    if (fe) begin fe_req = 1'b1; fe_ds = ds; fe_wdata = wd; end
    else    begin uc_req = 1'b1; uc_ds = ds; uc_wdata = wd; end
  endtask

  // Follows the head transfer cycle by cycle from the cycle after its grant
  // edge (cycle 1) to cycle 'stop'; the ack arrives in cycle 6.
  task automatic trace(input int stop, input bit drop);
    xfer_t       e;
    bit          rd, act;
    logic [35:0] exp_ds, exp_wd;
    e  = sb[0];
    rd = e.ds[0];
    for (int c = 1; c <= stop; c++) begin
      @(posedge clk); #1;
      ebus_rdata = (c == 3 || c == 4) ? e.rv : ~e.rv;
      act    = (c <= 5);
      exp_ds = act ? 36'(e.ds) : 36'd0;
      exp_wd = (act && !rd) ? 36'(e.wd) : 36'd0;
      chk("ds_out", 36'(ds_out), exp_ds);
      chk("diag_strobe", 36'(diag_strobe), 36'(c == 3 || c == 4));
      chk("data_oe", 36'(data_oe), 36'(act && !rd));
      chk("ebus_wdata", ebus_wdata, exp_wd);
      chk("busy", 36'(busy), 36'd1);
      chk("console_owner", 36'(console_owner), 36'(e.fe));
      chk("fe_ack", 36'(fe_ack), 36'(e.fe && c == 6));
      chk("uc_ack", 36'(uc_ack), 36'(!e.fe && c == 6));
      if (c == 6) begin
        void'(sb.pop_front());
        chk("rdata", rdata, e.exp_rd);
        if (drop) begin
          if (e.fe) fe_req = 1'b0;
          else      uc_req = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_busy", 36'(busy), 36'd0);
    chk("idle_ds_out", 36'(ds_out), 36'd0);
    chk("idle_acks", 36'({fe_ack, uc_ack}), 36'd0);
    chk("idle_owner", 36'(console_owner), 36'd0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ds_out"}, 36'(ds_out), 36'd0);
    chk({tag, "_strobe"}, 36'(diag_strobe), 36'd0);
    chk({tag, "_data_oe"}, 36'(data_oe), 36'd0);
    chk({tag, "_ebus_wdata"}, ebus_wdata, 36'd0);
    chk({tag, "_rdata"}, rdata, 36'd0);
    chk({tag, "_acks"}, 36'({fe_ack, uc_ack}), 36'd0);
    chk({tag, "_owner"}, 36'(console_owner), 36'd0);
    chk({tag, "_busy"}, 36'(busy), 36'd0);
  endtask

  initial begin
    logic [0:35] wd1;
    logic [0:6]  p_ds;
    reset = 1'b1;
    fe_req = 0; uc_req = 0; fe_ds = 0; uc_ds = 0; fe_wdata = 0; uc_wdata = 0;
    ebus_rdata = 0; mdl_rd = 0;
    p_fe_req = 0; p_fe_ds = 0; p_fe_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    chk("p_reset_busy", 36'(p_busy), 36'd0);
    chk("p_reset_ds", 36'(p_ds_out), 36'd0);
    reset = 1'b0;
    idle_cycle();

    // console load 076, data bits 24..28 = 10110
    wd1 = '0;
    wd1[24:28] = 5'b10110;
    request(1'b1, 7'o076, wd1, 36'o0);
    trace(6, 1'b1);
    idle_cycle();

    // microcode read 100
    request(1'b0, 7'o100, 36'o0, 36'o123456701234);
    trace(6, 1'b1);
    idle_cycle();

    // simultaneous requests: console first, uc granted in the following IDLE
    request(1'b1, 7'o012, 36'o707070707070, 36'o0);
    request(1'b0, 7'o101, 36'o0, 36'o555000333111);
    trace(6, 1'b1);
    idle_cycle();
    trace(6, 1'b1);
    idle_cycle();

    // load must leave rdata holding the previous read value
    request(1'b0, 7'o034, 36'o111122223333, 36'o0);
    trace(6, 1'b1);
    idle_cycle();

    // reset during the second STROBE cycle of a read, req held throughout
    request(1'b0, 7'o102, 36'o0, 36'o246024602460);
    trace(4, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    all_zero("abort");
    reset = 1'b0;
    sb.delete();
    mdl_rd = 0;
    request(1'b0, 7'o102, 36'o0, 36'o135713571357);
    trace(6, 1'b1);
    idle_cycle();

    // uc_req held for three back-to-back transfers, 7-cycle spacing
    request(1'b0, 7'o061, 36'o123123123123, 36'o0);
    request(1'b0, 7'o061, 36'o123123123123, 36'o0);
    request(1'b0, 7'o061, 36'o123123123123, 36'o0);
    trace(6, 1'b0);
    idle_cycle();
    trace(6, 1'b0);
    idle_cycle();
    trace(6, 1'b1);
    idle_cycle();
    idle_cycle();
    chk("sb_drained", 36'(sb.size()), 36'd0);

    // non-default timing: 1 setup, 3 strobe, 2 hold -> ack in cycle 7
    p_ds = 7'o076;
    p_fe_req = 1'b1; p_fe_ds = p_ds; p_fe_wdata = 36'o765432107654;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      chk("p_ds_out", 36'(p_ds_out), (c <= 6) ? 36'(p_ds) : 36'd0);
      chk("p_strobe", 36'(p_diag_strobe), 36'(c >= 2 && c <= 4));
      chk("p_data_oe", 36'(p_data_oe), 36'(c <= 6));
      chk("p_fe_ack", 36'(p_fe_ack), 36'(c == 7));
      chk("p_uc_ack", 36'(p_uc_ack), 36'd0);
      chk("p_owner", 36'(p_console_owner), 36'd1);
      if (c == 7) p_fe_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("p_idle_busy", 36'(p_busy), 36'd0);
    chk("p_rdata", p_rdata, 36'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ebus_diag_seq.md
Name: ebus_diag_seq

Overview:
- Sequences diagnostic function transfers on the EBUS diagnostic lines (DS[0:6], diag strobe, data[0:35]) that the CTL board decodes into DIAG_LOAD_FUNC_0xx and DIAG_READ_FUNC_1xx.
- Arbitrates between two requesters: the front-end console and microcode COND/DIAG_FUNC (function code taken from CRAM MAGIC[2:8]).
- Generates correctly timed setup, strobe and hold phases, drives write data for load functions and captures read-back data for read functions.
- Sits between the EBUS interface and the two requesters, above CTL.

Parameters:
- SETUP_CYC, 2, cycles DS/data are stable before strobe rises (≥1)
- STROBE_CYC, 2, cycles strobe is held high (≥1)
- HOLD_CYC, 1, cycles DS/data are held after strobe falls (≥1)

Ports:
- clk  in  1  EBOX clock
- reset  in  1  synchronous, active-high reset
- fe_req  in  1  console request (level, held until fe_ack)
- fe_ds  in  7  console function code [0:6]
- fe_wdata  in  36  console load data [0:35]
- fe_ack  out  1  one-cycle completion pulse to console
- uc_req  in  1  microcode request (level, held until uc_ack)
- uc_ds  in  7  microcode function code (MAGIC[2:8])
- uc_wdata  in  36  microcode load data (AD)
- uc_ack  out  1  one-cycle completion pulse to microcode
- rdata  out  36  captured read data, valid with the ack of a read function
- ds_out  out  7  EBUS DS[0:6]
- diag_strobe  out  1  EBUS diag strobe
- data_oe  out  1  drive ebus_wdata onto EBUS data
- ebus_wdata  out  36  EBUS data out
- ebus_rdata  in  36  EBUS data in
- console_owner  out  1  high while the console holds the grant
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- One clock, `clk`. `reset` is synchronous and active-high.
- Reset values: state IDLE, all outputs 0. This includes ds_out, diag_strobe, data_oe, ebus_wdata, rdata, both acks, console_owner and busy.
- States: IDLE → SETUP → STROBE → HOLD → DONE → IDLE.
- A function is a read when ds[0]=1 (1xx codes) and a load when ds[0]=0.
- IDLE:
  - Sample requests each cycle.
  - fe_req has absolute priority; if both are high, the console wins and uc_req stays pending.
  - On grant, register the winner's ds, wdata and read flag, set console_owner for a console grant, and go to SETUP.
  - Requester inputs are ignored after the grant edge; dropping req mid-operation does not abort it.
- SETUP (SETUP_CYC cycles):
  - ds_out holds the latched code; diag_strobe=0.
  - For loads: data_oe=1 and ebus_wdata holds the latched data.
  - For reads: data_oe=0 and ebus_wdata=0.
- STROBE (STROBE_CYC cycles):
  - diag_strobe=1; DS and data are unchanged.
  - For reads, rdata←ebus_rdata on the edge ending the last STROBE cycle.
- HOLD (HOLD_CYC cycles): diag_strobe=0; DS and data are still held.
- DONE (1 cycle):
  - ds_out=0, data_oe=0.
  - The winner's ack=1 and the other ack stays 0.
  - rdata holds its value until the next read capture; it is not cleared on loads.
  - console_owner clears on exit.
- Latency: req sampled at edge k → ack high in cycle k+SETUP_CYC+STROBE_CYC+HOLD_CYC+1. With defaults: 6 cycles after the grant edge, 7-cycle period per transfer.
- The requester deasserts req at the edge ending its ack cycle. A req still high in IDLE after DONE starts a new transfer (back-to-back is legal).
- A single cycle counter serves all timed phases. It is reloaded on every state entry and sized $clog2 of the largest parameter plus 1. There is no wrap-around.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs 0. No ack is issued, and the aborted transfer is not retried automatically.
- A uc request made while the console is being served is granted in the IDLE cycle after the console's DONE, provided fe_req is then low.
- Console starvation of microcode is permitted by design.
- Outputs are registered, so there are no combinational paths from req to EBUS.

Decomposition:
- Shared package ebus_diag_pkg:
  - state enum diag_seq_state_t (IDLE, SETUP, STROBE, HOLD, DONE)
  - DS width constant (7), data width constant (36)
  - named function-code constants (e.g. DS_LD_FUNC_076 = 7'o076, DS_READ_10x base)
- One natural sub-module, ebus_diag_arb: a fixed-priority two-way grant with a grant-hold register. All other logic lives in ebus_diag_seq.

Test Plan:
- Console load 076 with fe_wdata[24:28]=5'b10110 (defaults) → ds_out=7'o076 and data_oe=1 for 5 cycles; strobe high for exactly 2 cycles starting the 3rd; fe_ack in cycle 6; uc_ack stays 0.
- Microcode read 7'o100 with ebus_rdata=36'o123456701234 during strobe → data_oe=0 throughout; rdata=36'o123456701234 with uc_ack; ebus_wdata=0.
- fe_req and uc_req asserted in the same cycle → console served first with console_owner=1; uc transfer starts in the IDLE cycle after fe_ack; both acks pulse exactly once.
- reset asserted during the 2nd STROBE cycle → next cycle has all outputs 0 and state IDLE; no ack; held req granted on the first IDLE cycle after reset drops.
- uc_req held high for 3 transfers → consecutive transfers spaced exactly 7 cycles apart; one uc_ack per transfer.
- SETUP_CYC=1, STROBE_CYC=3, HOLD_CYC=2 → strobe width 3; ack in cycle 7 after grant; DS stable across all non-IDLE/DONE cycles.
